// File: rtl/sgd_engine.sv
// sgd_engine: streaming fixed-point SGD trainer for linear regression.
// Samples are fetched over a request/valid handshake, y_cap is formed with
// NUM_MUL time-shared multipliers, and weights are updated per sample.
module sgd_engine #(
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned FRAC         = 8,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned NUM_MUL      = 4,
  parameter int unsigned ADDR_WIDTH   = 12
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                start,
  input  logic                                hold,
  input  logic [3:0]                          feat,
  input  logic [ADDR_WIDTH-1:0]               data_points,
  input  logic [7:0]                          epoch,
  input  logic [3:0]                          learn_rate,
  input  logic [LENGTH*(MAX_FEATURES+1)-1:0]  w_init,
  output logic                                rd_req,
  output logic [ADDR_WIDTH-1:0]               addr,
  input  logic [LENGTH*(MAX_FEATURES+1)-1:0]  data_in,
  input  logic                                data_valid,
  output logic [LENGTH*(MAX_FEATURES+1)-1:0]  w_out,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned NW = MAX_FEATURES + 1;
  localparam int unsigned AW = LENGTH + 8;
  localparam int unsigned PW = 2 * LENGTH;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned CW = $clog2(MAX_FEATURES + 1);

  localparam logic signed [SW-1:0] WMAX = {{(SW-LENGTH+1){1'b0}}, {(LENGTH-1){1'b1}}};
  localparam logic signed [SW-1:0] WMIN = {{(SW-LENGTH+1){1'b1}}, {(LENGTH-1){1'b0}}};

  typedef logic signed [LENGTH-1:0] word_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOADW, S_FETCH, S_WAIT, S_MAC, S_ERR, S_UPD, S_NEXT, S_DONE
  } state_t;

  function automatic word_t sat(input logic signed [SW-1:0] v);
    if (v > WMAX)      return WMAX[LENGTH-1:0];
    else if (v < WMIN) return WMIN[LENGTH-1:0];
    else               return v[LENGTH-1:0];
  endfunction

  state_t                               state_q;
  word_t                                w_q   [NW];
  word_t                                smp_q [NW];   // [0] = y, [j] = xj
  logic [LENGTH*(MAX_FEATURES+1)-1:0]   winit_q;
  logic [3:0]                           feat_q;
  logic [ADDR_WIDTH-1:0]                dp_q;
  logic [7:0]                           ep_q;
  logic [3:0]                           lr_q;
  logic [ADDR_WIDTH-1:0]                sample_q;
  logic [7:0]                           epoch_cnt_q;
  logic [CW-1:0]                        pass_q;
  logic signed [AW-1:0]                 acc_q;
  word_t                                delta_q;
  logic                                 got_q;
  logic                                 rd_req_q;
  logic [ADDR_WIDTH-1:0]                addr_q;
  logic                                 busy_q;
  logic                                 done_q;

  logic                                 lane_en  [NUM_MUL];
  int unsigned                          lane_idx [NUM_MUL];
  word_t                                lane_w   [NUM_MUL];
  word_t                                lane_x   [NUM_MUL];
  word_t                                lane_new [NUM_MUL];
  logic signed [PW-1:0]                 prod_sh  [NUM_MUL];
  logic signed [AW-1:0]                 mac_sum_c;
  logic                                 last_pass_c;
  word_t                                ycap_c;
  word_t                                err_c;
  word_t                                delta_c;
  word_t                                dsrc_c;
  word_t                                w0_new_c;

  // Lane operand selection, shared multipliers, MAC sum and update values
  always_comb begin
    mac_sum_c   = acc_q;
    last_pass_c = ((32'(pass_q) + 1) * NUM_MUL) >= 32'(feat_q);
    for (int unsigned m = 0; m < NUM_MUL; m++) begin
      lane_idx[m] = 32'(pass_q) * NUM_MUL + m + 1;
      lane_en[m]  = lane_idx[m] <= 32'(feat_q);
      lane_w[m]   = '0;
      lane_x[m]   = '0;
      for (int unsigned k = 1; k < NW; k++) begin
        if (lane_en[m] && lane_idx[m] == k) begin
          lane_w[m] = w_q[k];
          lane_x[m] = smp_q[k];
        end
      end
      // MAC multiplies weight*x, UPD reuses the same multiplier for delta*x
      prod_sh[m]  = (PW'((state_q == S_UPD) ? delta_q : lane_w[m]) * PW'(lane_x[m])) >>> FRAC;
      lane_new[m] = sat(SW'(lane_w[m]) + SW'(sat(SW'(prod_sh[m]))));
      if (lane_en[m]) mac_sum_c = mac_sum_c + AW'(prod_sh[m]);
    end
    ycap_c   = sat(SW'(acc_q));
    err_c    = sat(SW'(smp_q[0]) - SW'(ycap_c));
    delta_c  = err_c >>> lr_q;
    dsrc_c   = (state_q == S_ERR) ? delta_c : delta_q;
    w0_new_c = sat(SW'(w_q[0]) + SW'(dsrc_c));
  end

  // Training FSM with all datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      for (int unsigned k = 0; k < NW; k++) begin
        w_q[k]   <= '0;
        smp_q[k] <= '0;
      end
      winit_q     <= '0;
      feat_q      <= '0;
      dp_q        <= '0;
      ep_q        <= '0;
      lr_q        <= '0;
      sample_q    <= '0;
      epoch_cnt_q <= '0;
      pass_q      <= '0;
      acc_q       <= '0;
      delta_q     <= '0;
      got_q       <= 1'b0;
      rd_req_q    <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            feat_q  <= feat;
            dp_q    <= data_points;
            ep_q    <= epoch;
            lr_q    <= learn_rate;
            winit_q <= w_init;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_LOADW;
          end
        end
        default: begin
          // A sample arriving while held is kept; the FSM resumes with it later
          if (state_q == S_WAIT && data_valid && !got_q) begin
            for (int unsigned k = 0; k < NW; k++)
              smp_q[k] <= data_in[LENGTH*(NW-k)-1 -: LENGTH];
            got_q <= 1'b1;
          end
          if (!hold) begin
            case (state_q)
              S_LOADW: begin
                for (int unsigned k = 0; k < NW; k++)
                  w_q[k] <= winit_q[LENGTH*(NW-k)-1 -: LENGTH];
                sample_q    <= ADDR_WIDTH'(1);
                epoch_cnt_q <= '0;
                if (ep_q == '0 || dp_q == '0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  state_q <= S_FETCH;
                end
              end
              S_FETCH: begin
                rd_req_q <= 1'b1;
                addr_q   <= sample_q;
                state_q  <= S_WAIT;
              end
              S_WAIT: begin
                if (data_valid || got_q) begin
                  got_q   <= 1'b0;
                  acc_q   <= AW'(w_q[0]);
                  pass_q  <= '0;
                  state_q <= (feat_q == '0) ? S_ERR : S_MAC;
                end
              end
              S_MAC: begin
                acc_q <= mac_sum_c;
                if (last_pass_c) begin
                  pass_q  <= '0;
                  state_q <= S_ERR;
                end else begin
                  pass_q  <= pass_q + CW'(1);
                end
              end
              S_ERR: begin
                delta_q <= delta_c;
                pass_q  <= '0;
                if (feat_q == '0) begin
                  w_q[0]  <= w0_new_c;
                  state_q <= S_NEXT;
                end else begin
                  state_q <= S_UPD;
                end
              end
              S_UPD: begin
                if (pass_q == '0) w_q[0] <= w0_new_c;
                for (int unsigned k = 1; k < NW; k++)
                  for (int unsigned m = 0; m < NUM_MUL; m++)
                    if (lane_en[m] && lane_idx[m] == k) w_q[k] <= lane_new[m];
                if (last_pass_c) begin
                  pass_q  <= '0;
                  state_q <= S_NEXT;
                end else begin
                  pass_q  <= pass_q + CW'(1);
                end
              end
              S_NEXT: begin
                if (sample_q < dp_q) begin
                  sample_q <= sample_q + ADDR_WIDTH'(1);
                  state_q  <= S_FETCH;
                end else if (({1'b0, epoch_cnt_q} + 9'd1) < {1'b0, ep_q}) begin
                  sample_q    <= ADDR_WIDTH'(1);
                  epoch_cnt_q <= epoch_cnt_q + 8'd1;
                  state_q     <= S_FETCH;
                end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end
              end
              default: state_q <= state_q;
            endcase
          end
        end
      endcase
    end
  end

  // Weight bus packing, w0 in the top slice
  always_comb begin
    for (int unsigned k = 0; k < NW; k++)
      w_out[LENGTH*(NW-k)-1 -: LENGTH] = w_q[k];
  end

  assign rd_req = rd_req_q;
  assign addr   = addr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/sgd_engine.md
Name: sgd_engine

Overview:
- Parametrised successor to the single-configuration SGD linear-regression trainer.
- Streams samples from the dataset RAM over a request/valid handshake and computes y_cap = w0 + sum(wj*xj) with NUM_MUL time-shared multipliers.
- Applies fixed-point SGD weight updates over a programmable number of samples and epochs.
- Exposes the trained weights on a dedicated bus and supports pause (hold) and restart.

Parameters:
- LENGTH, 16, bit width of every feature, label and weight (signed two's complement).
- FRAC, 8, fractional bits of the fixed-point format (1.0 = 2^FRAC).
- MAX_FEATURES, 15, maximum feature count.
- NUM_MUL, 4, number of physical multipliers; must be 1..MAX_FEATURES.
- ADDR_WIDTH, 12, RAM address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- start  in  1  one-cycle pulse; latches config and w_init, begins training.
- hold  in  1  while high, FSM freezes in its current state.
- feat  in  4  active feature count, 0..MAX_FEATURES.
- data_points  in  ADDR_WIDTH  samples per epoch.
- epoch  in  8  number of epochs.
- learn_rate  in  4  right-shift applied to the error.
- w_init  in  LENGTH*(MAX_FEATURES+1)  initial weights; w0 in the MSB slice.
- rd_req  out  1  one-cycle read request.
- addr  out  ADDR_WIDTH  sample address, 1-based.
- data_in  in  LENGTH*(MAX_FEATURES+1)  sample; MSB slice = y, next slice = x1, down to x15.
- data_valid  in  1  data_in valid.
- w_out  out  LENGTH*(MAX_FEATURES+1)  current weights, same packing as w_init.
- busy  out  1  training in progress.
- done  out  1  training complete, sticky.

Behaviour:
- Clock and reset: single clock CLK, rising edge. RST is asynchronous, active-high.
- Reset values: all weights 0, rd_req=0, addr=0, busy=0, done=0, FSM=IDLE. All counters 0. RST mid-run aborts immediately.
- Config latch: start latches feat, data_points, epoch, learn_rate and w_init. start is ignored while busy. start in DONE clears done and restarts.
- IDLE -> LOADW on start.
- LOADW (1 cycle): weights <= w_init; sample=1; epoch_cnt=0. Goes to DONE if epoch==0 or data_points==0, else FETCH.
- FETCH (1 cycle): rd_req=1, addr=sample. -> WAIT.
- WAIT: stays until data_valid=1, then latches data_in into the sample buffer. data_valid in any other state is ignored. -> MAC.
- MAC: P = ceil(feat/NUM_MUL) cycles; pass k multiplies features k*NUM_MUL+1 .. k*NUM_MUL+NUM_MUL.
  - Features with index > feat contribute 0.
  - Accumulator: LENGTH+8 bits, preloaded with w0.
  - Each product: full 2*LENGTH signed product, arithmetic shift right by FRAC, then added.
  - feat==0 gives P=0 and MAC is skipped.
- ERR (1 cycle): y_cap = sat_LENGTH(acc); err = sat_LENGTH(y - y_cap); delta = err >>> learn_rate (arithmetic).
- UPD: P cycles, same pass grouping as MAC.
  - wj <= sat_LENGTH(wj + sat_LENGTH((delta*xj) >>> FRAC)) for j <= feat.
  - w0 <= sat_LENGTH(w0 + delta), applied in the first UPD cycle (or within ERR when P=0).
  - Weights with index > feat are never modified.
- NEXT (1 cycle), three cases:
  - sample < data_points: sample++, -> FETCH.
  - sample == data_points and epoch_cnt+1 < epoch: sample=1, epoch_cnt++, -> FETCH.
  - otherwise -> DONE.
- Per-sample latency: 1 + wait + P + 1 + P + 1 cycles.
- DONE: done=1, busy=0; weights held. Stays until start or RST.
- busy is 1 in every state except IDLE and DONE.
- Saturation: sat_LENGTH clamps to [-2^(LENGTH-1), 2^(LENGTH-1)-1].
- hold:
  - All state, counters and weights freeze; rd_req is forced 0.
  - A data_valid arriving in WAIT while hold=1 is still captured, but the FSM does not advance until hold falls.
  - hold has no effect in IDLE or DONE.
- w_out: continuously reflects the weight registers.
- Simultaneous start and RST: RST wins.

Test Plan:
1. Single update (FRAC=8): feat=1, data_points=1, epoch=1, lr=1, w_init=0, x1=256, y=512 -> err=512, delta=256, w0=256, w1=256, done=1, exactly one rd_req at addr=1.
2. Saturation: feat=1, lr=0, w0=0, w1=32767, x1=32767, y=-32768 -> y_cap=32767, err=-32768, w0=-32768, w1=-1.
3. Partial passes (NUM_MUL=4): feat=6, x7..x15=1000, w7..w15=7 -> MAC and UPD each take exactly 2 cycles; w7..w15 stay 7; only w0..w6 change.
4. Degenerate config: epoch=0 (and separately data_points=0) -> done=1 two cycles after start, w_out=w_init, no rd_req.
5. Multi-epoch addressing: data_points=3, epoch=2, data_valid 2 cycles after each rd_req -> addr sequence 1,2,3,1,2,3, exactly 6 rd_req pulses, then done.
6. Control: hold=1 for 10 cycles mid-UPD -> weights and addr frozen, no rd_req; final weights match an unheld run. RST mid-MAC -> all outputs return to reset values; the next start trains correctly.
